// File: rtl/leaf_response_collector.sv
// rtl/leaf_response_collector.sv - round-robin merge of leaf responses into one registered output stream
module leaf_response_collector #(
    parameter int NUM_LEAVES = 5,
    parameter int DATA_W     = 16,
    parameter int CNT_W      = 16,
    parameter int SRC_W      = $clog2(NUM_LEAVES)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_LEAVES-1:0]        leaf_valid,
    input  logic [NUM_LEAVES*DATA_W-1:0] leaf_data,
    output logic [NUM_LEAVES-1:0]        leaf_ready,
    output logic                         out_valid,
    output logic [DATA_W-1:0]            out_data,
    output logic [SRC_W-1:0]             out_src,
    input  logic                         out_ready,
    output logic [CNT_W-1:0]             txn_count
);

    // The output register is the only state; its occupancy is out_valid.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [SRC_W-1:0]  last_grant_q;
    logic [SRC_W-1:0]  grant;
    logic              grant_found;
    logic              load;
    logic [DATA_W-1:0] out_data_q;
    logic [SRC_W-1:0]  out_src_q;
    logic [CNT_W-1:0]  txn_q;

    // Round-robin search: start just after the last winner and wrap; first valid leaf wins.
    always_comb begin
        int idx;
        idx         = 0;
        grant       = '0;
        grant_found = 1'b0;
        for (int i = 0; i < NUM_LEAVES; i++) begin
            idx = int'(last_grant_q) + 1 + i;
            if (idx >= NUM_LEAVES) begin
                idx = idx - NUM_LEAVES;
            end
            if (!grant_found && leaf_valid[idx]) begin
                grant       = SRC_W'(idx);
                grant_found = 1'b1;
            end
        end
    end

    // Accept a leaf when the output slot is free or being drained this cycle.
    always_comb begin
        load       = (state_q == EMPTY || out_ready) && grant_found && !rst;
        leaf_ready = '0;
        if (load) begin
            leaf_ready = NUM_LEAVES'(1) << grant;
        end
    end

    // Next occupancy: reload wins over drain so back-to-back transfers stay full.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = FULL;
        end else if (state_q == FULL && out_ready) begin
            state_d = EMPTY;
        end
    end

    // Occupancy register; reset discards any pending entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Output payload and arbitration pointer; both change only on an actual grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q   <= '0;
            out_src_q    <= '0;
            last_grant_q <= SRC_W'(NUM_LEAVES - 1);
        end else if (load) begin
            out_data_q   <= leaf_data[int'(grant)*DATA_W +: DATA_W];
            out_src_q    <= grant;
            last_grant_q <= grant;
        end
    end

    // Count completed output handshakes, wrapping freely.
    always_ff @(posedge clk) begin
        if (rst) begin
            txn_q <= '0;
        end else if (state_q == FULL && out_ready) begin
            txn_q <= txn_q + CNT_W'(1);
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign txn_count = txn_q;

endmodule

// File: tb/tb_leaf_response_collector.sv
// tb/tb_leaf_response_collector.sv - randomized and directed self-checking bench for leaf_response_collector
module tb_leaf_response_collector;

    localparam int N  = 5;
    localparam int DW = 16;
    localparam int CW = 4;
    localparam int SW = 3;

    logic            clk;
    logic            rst;
    logic [N-1:0]    leaf_valid;
    logic [N*DW-1:0] leaf_data;
    logic [N-1:0]    leaf_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [SW-1:0]   out_src;
    logic            out_ready;
    logic [CW-1:0]   txn_count;

    logic [DW-1:0]   ld [N];

    int n_total;
    int n_pass;

    // Reference state: what the outputs must show at the next sampling point.
    bit              m_known;
    bit              m_valid;
    int              m_data;
    int              m_src;
    int              m_last;
    int              m_count;

    leaf_response_collector #(
        .NUM_LEAVES(N),
        .DATA_W    (DW),
        .CNT_W     (CW),
        .SRC_W     (SW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .leaf_valid(leaf_valid),
        .leaf_data (leaf_data),
        .leaf_ready(leaf_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready),
        .txn_count (txn_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            leaf_data[i*DW +: DW] = ld[i];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Compare every cycle against the reference, then advance it across the coming edge.
    always @(negedge clk) begin
        int win;
        bit ld_now;
        logic [N-1:0] exp_rdy;
        win = -1;
        for (int k = 1; k <= N; k++) begin
            if (win < 0 && leaf_valid[(m_last + k) % N]) begin
                win = (m_last + k) % N;
            end
        end
        ld_now  = !rst && (win >= 0) && (!m_valid || out_ready);
        exp_rdy = '0;
        if (ld_now) begin
            exp_rdy[win] = 1'b1;
        end
        if (m_known) begin
            chk("mdl_out_valid", 32'(out_valid), 32'(m_valid));
            chk("mdl_out_data",  32'(out_data),  32'(m_data));
            chk("mdl_out_src",   32'(out_src),   32'(m_src));
            chk("mdl_txn_count", 32'(txn_count), 32'(m_count));
            chk("mdl_leaf_ready", 32'(leaf_ready), 32'(exp_rdy));
        end
        if (rst) begin
            m_known = 1'b1;
            m_valid = 1'b0;
            m_data  = 0;
            m_src   = 0;
            m_count = 0;
            m_last  = N - 1;
        end else begin
            if (m_valid && out_ready) begin
                m_count = (m_count + 1) % (1 << CW);
            end
            if (ld_now) begin
                m_valid = 1'b1;
                m_data  = int'(ld[win]);
                m_src   = win;
                m_last  = win;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all_a000();
        for (int i = 0; i < N; i++) begin
            ld[i] = 16'hA000 + 16'(i);
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        leaf_valid = '0;
        out_ready  = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [N-1:0] granted;
        n_total    = 0;
        n_pass     = 0;
        m_known    = 1'b0;
        m_valid    = 1'b0;
        m_data     = 0;
        m_src      = 0;
        m_last     = N - 1;
        m_count    = 0;
        rst        = 1'b1;
        leaf_valid = '1;
        out_ready  = 1'b0;
        set_all_a000();
        #1;

        // Reset holds leaf_ready low even with every leaf valid.
        @(negedge clk);
        chk("rst_leaf_ready", 32'(leaf_ready), 32'h0);
        step();

        // Single response from leaf 2.
        rst        = 1'b0;
        leaf_valid = 5'b00100;
        ld[2]      = 16'h1234;
        out_ready  = 1'b1;
        @(negedge clk);
        chk("t1_empty", 32'(out_valid), 32'h0);
        chk("t1_txn0", 32'(txn_count), 32'h0);
        chk("t1_ready", 32'(leaf_ready), 32'h04);
        step();
        leaf_valid = '0;
        @(negedge clk);
        chk("t1_valid", 32'(out_valid), 32'h1);
        chk("t1_data", 32'(out_data), 32'h1234);
        chk("t1_src", 32'(out_src), 32'h2);
        step();
        @(negedge clk);
        chk("t1_txn1", 32'(txn_count), 32'h1);
        chk("t1_drained", 32'(out_valid), 32'h0);

        // All leaves valid: rotation 0,1,2,3,4,0 at one transfer per cycle.
        step();
        do_reset();
        set_all_a000();
        leaf_valid = '1;
        out_ready  = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            chk("rr_ready", 32'(leaf_ready), 32'(1 << (k % N)));
            if (k >= 1) begin
                chk("rr_src", 32'(out_src), 32'((k - 1) % N));
                chk("rr_data", 32'(out_data), 32'h0000A000 + 32'((k - 1) % N));
                chk("rr_txn", 32'(txn_count), 32'(k - 1));
            end
            step();
        end

        // Pointer at 2, then leaves 0 and 4 compete: 4 goes first.
        do_reset();
        leaf_valid = 5'b00100;
        out_ready  = 1'b1;
        step();
        leaf_valid = 5'b10001;
        @(negedge clk);
        chk("ptr_first4", 32'(leaf_ready), 32'h10);
        step();
        leaf_valid = 5'b00001;
        @(negedge clk);
        chk("ptr_then0", 32'(leaf_ready), 32'h01);
        chk("ptr_src4", 32'(out_src), 32'h4);
        step();

        // Backpressure for 3 cycles while holding leaf 0's entry.
        leaf_valid = '1;
        out_ready  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_ready", 32'(leaf_ready), 32'h0);
            chk("bp_src", 32'(out_src), 32'h0);
            chk("bp_data", 32'(out_data), 32'hA000);
            chk("bp_txn", 32'(txn_count), 32'h2);
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 32'(leaf_ready), 32'h02);
        step();
        @(negedge clk);
        chk("bp_reload_src", 32'(out_src), 32'h1);
        chk("bp_reload_txn", 32'(txn_count), 32'h3);
        step();

        // 17 handshakes on a 4-bit counter wraps to 1.
        do_reset();
        leaf_valid = '1;
        out_ready  = 1'b1;
        for (int k = 0; k < 18; k++) begin
            step();
        end
        @(negedge clk);
        chk("wrap_txn", 32'(txn_count), 32'h1);

        // Reset while full and stalled discards the entry.
        out_ready = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("midrst_valid", 32'(out_valid), 32'h0);
        chk("midrst_txn", 32'(txn_count), 32'h0);
        chk("midrst_ready", 32'(leaf_ready), 32'h01);
        step();

        // Random traffic with protocol-respecting leaves and occasional reset.
        leaf_valid = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            granted = leaf_ready;
            @(posedge clk);
            #1;
            rst       = ($urandom_range(0, 199) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (!leaf_valid[i] || granted[i]) begin
                    leaf_valid[i] = ($urandom_range(0, 2) != 0);
                    ld[i]         = 16'($urandom);
                end
            end
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/leaf_response_collector.md
Name: leaf_response_collector

Overview:
- Gathers results from the leaf instances that a hierarchy node fans out to, and merges them into one ordered stream at the parent.
- It is the return path of that fan-out: the parent sends work out to the leaves, and this block brings the leaf responses back in.
- It has NUM_LEAVES valid/ready input channels, a round-robin arbiter, a single-entry registered output stage and a completed-transaction counter.

Parameters:
- NUM_LEAVES, 5, number of leaf channels (2..16).
- DATA_W, 16, payload width per leaf.
- CNT_W, 16, width of the transaction counter.
- SRC_W, $clog2(NUM_LEAVES), width of the source index.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- leaf_valid  in  NUM_LEAVES  per-leaf response valid.
- leaf_data  in  NUM_LEAVES*DATA_W  packed payloads; leaf i occupies bits [i*DATA_W +: DATA_W].
- leaf_ready  out  NUM_LEAVES  per-leaf accept, one-hot or zero.
- out_valid  out  1  merged response valid.
- out_data  out  DATA_W  merged payload.
- out_src  out  SRC_W  index of the leaf that produced out_data.
- out_ready  in  1  downstream accept.
- txn_count  out  CNT_W  number of completed output handshakes.

Behaviour:
- Reset (rst=1 at a clock edge):
  - out_valid=0, out_data=0, out_src=0, txn_count=0, last_grant=NUM_LEAVES-1.
  - leaf_ready is forced to 0 combinationally while rst=1.
- Handshake rules:
  - A transfer happens on a cycle where valid&&ready.
  - Leaves must hold valid and data stable until ready; the collector does the same on its output.
  - out_valid never drops without a handshake, except on reset.
- States, encoded by out_valid:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- Load enable: load = (!out_valid || out_ready) && |leaf_valid && !rst.
- Arbitration:
  - Combinational round-robin.
  - Search leaf indices starting at (last_grant+1) mod NUM_LEAVES and wrapping; the first asserted leaf_valid wins.
  - leaf_ready[g]=1 only for winner g, and only when load=1; all other bits are 0.
  - leaf_ready may depend combinationally on leaf_valid and out_ready.
- On load:
  - out_data<=leaf_data[g], out_src<=g, out_valid<=1, last_grant<=g.
- Transitions:
  - EMPTY -> FULL on load.
  - FULL and out_ready=1 with no leaf valid -> EMPTY.
  - FULL and out_ready=1 with a leaf valid -> stays FULL and reloads in the same cycle. This is back-to-back, 1 transfer per cycle.
  - FULL and out_ready=0 -> hold all outputs; leaf_ready=0.
- Latency: 1 cycle from leaf handshake to out_valid/out_data.
- Priority after reset: leaf 0 first.
- last_grant updates only on an actual grant, never on idle cycles.
- txn_count:
  - Increments by 1 on each output handshake (out_valid&&out_ready).
  - Wraps from 2^CNT_W-1 to 0 with no saturation.
- Simultaneous events: an output handshake and a new load in the same cycle are both counted and both take effect.
- Reset mid-operation: a pending output entry is discarded and not counted; arbitration restarts at leaf 0.
- out_data and out_src are don't-care-stable while out_valid=0: they keep their last value.

Test Plan:
- Reset, then leaf_valid=00100 with data 0x1234 and out_ready=1 -> next cycle out_valid=1, out_data=0x1234, out_src=2, leaf_ready=00100 on the accept cycle; txn_count=1 after the output handshake.
- All five leaves valid continuously with data 0xA000+i and out_ready=1 -> out_src sequence 0,1,2,3,4,0 on consecutive cycles; each leaf_ready pulses once per 5 cycles; txn_count=5 after 5 outputs.
- Last grant=2, then only leaves 0 and 4 valid -> leaf 4 is granted before leaf 0.
- Backpressure: out_ready=0 for 3 cycles while FULL with leaves valid -> out_data/out_src stable, leaf_ready=0, txn_count unchanged. Releasing out_ready -> handshake plus reload in the same cycle.
- Counter wrap with CNT_W=4: 17 handshakes -> txn_count=1.
- Reset asserted while FULL with out_ready=0 -> next cycle out_valid=0 and txn_count=0. After release with all leaves valid, leaf 0 is granted first.
